// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result bus of the sequential ALU.
//   master : operand source and result sink (drives in_valid, a, b, cin, op,
//            out_ready; observes in_ready and the result group).
//   slave  : the ALU (accepts commands, returns result, carry, zero,
//            div_by_zero under out_valid/out_ready).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   cin;
  logic [2:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic                   carry;
  logic                   zero;
  logic                   div_by_zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, carry, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned ALU (add, sub, mul, div) on WIDTH-bit operands.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave
//           in_valid/in_ready handshake carrying a, b, cin, op
//           out_valid/out_ready handshake carrying result, carry, zero,
//           div_by_zero
// add/sub/reserved/div-by-zero finish on the accept edge; mul (shift-add) and
// div (restoring) run WIDTH iterations, one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     b_reg;
  logic                 is_div_reg;
  logic [WIDTH-1:0]     hi_reg;      // mul: partial product high half; div: remainder
  logic [WIDTH-1:0]     lo_reg;      // mul: multiplier/low product; div: dividend/quotient
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 carry_reg;
  logic                 zero_reg;
  logic                 dbz_reg;

  logic                 accept;
  logic                 b_is_zero;
  logic                 last_iter;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_sum;
  logic [2*WIDTH-1:0]   quick_result;
  logic                 quick_carry;
  logic                 quick_dbz;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     iter_hi;
  logic [WIDTH-1:0]     iter_lo;

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign b_is_zero = (bus.b == '0);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Subtraction as a + ~b + 1: bit WIDTH is the carry-out, whose inverse is
  // the borrow (a < b).
  assign add_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

  // Results of the ops that complete on the accept edge.
  always_comb begin
    quick_result = '0;
    quick_carry  = 1'b0;
    quick_dbz    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        quick_result = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
        quick_carry  = add_sum[WIDTH];
      end
      OP_SUB: begin
        quick_result = {{WIDTH{1'b0}}, sub_sum[WIDTH-1:0]};
        quick_carry  = ~sub_sum[WIDTH];
      end
      OP_DIV: begin
        // Only taken when b == 0: quotient saturates, remainder is a.
        quick_result = {bus.a, {WIDTH{1'b1}}};
        quick_dbz    = 1'b1;
      end
      default: begin
        quick_result = '0;
      end
    endcase
  end

  // One shift-add step: add b when the current multiplier bit is set, then
  // shift the {carry, hi, lo} chain right by one.
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);

  // One restoring-division step. The shifted partial remainder is always
  // below 2*b, so bit WIDTH of the difference is set exactly when it went
  // negative.
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ge    = ~div_diff[WIDTH];

  always_comb begin
    iter_hi = mul_sum[WIDTH:1];
    iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {lo_reg[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && !b_is_zero)) begin
            state_next = BUSY;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      b_reg      <= '0;
      is_div_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // mul and div share the same start: hi = 0, lo = a.
            b_reg      <= bus.b;
            is_div_reg <= bus.op[0];
            hi_reg     <= '0;
            lo_reg     <= bus.a;
            cnt_reg    <= '0;
            if (state_next == DONE) begin
              result_reg <= quick_result;
              carry_reg  <= quick_carry;
              zero_reg   <= (quick_result == '0);
              dbz_reg    <= quick_dbz;
            end
          end
        end
        BUSY: begin
          hi_reg  <= iter_hi;
          lo_reg  <= iter_lo;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            result_reg <= {iter_hi, iter_lo};
            carry_reg  <= 1'b0;
            zero_reg   <= ({iter_hi, iter_lo} == '0);
            dbz_reg    <= 1'b0;
          end
        end
        default: begin
          // DONE holds every output until the hand-off.
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.result      = result_reg;
  assign bus.carry       = carry_reg;
  assign bus.zero        = zero_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command on the 8-bit DUT and wait (bounded) for out_valid.
  // lat counts clock edges from the accept edge (inclusive) to out_valid.
  // ready_low stays 1 if in_ready was low on every sample while waiting.
  task automatic issue8(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        output int lat, output bit ready_low);
    @(negedge clk);
    if8.op = op; if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1;
    ready_low = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 100) begin
      if (if8.in_ready) ready_low = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat);
    @(negedge clk);
    if16.op = op; if16.a = a; if16.b = b; if16.cin = 1'b0; if16.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if16.in_valid = 1'b0;
    while (!if16.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Complete the result hand-off on the 8-bit DUT; returns at a negedge.
  task automatic handoff8();
    if8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    $display("reset: in_ready=%0b out_valid=%0b result=%h", if8.in_ready, if8.out_valid, if8.result);
    n_vec++; if (if8.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", if8.in_ready); end
    n_vec++; if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", if8.out_valid); end
    n_vec++; if ({if8.result, if8.carry, if8.zero, if8.div_by_zero} !== 19'h0) begin
      n_err++; $display("FAIL reset_outputs: got result=%h c=%b z=%b dbz=%b expected all 0", if8.result, if8.carry, if8.zero, if8.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat; bit rl;
    issue8(3'b000, 8'd200, 8'd100, 1'b1, lat, rl);
    $display("add 200+100+1: result=%h carry=%b zero=%b lat=%0d", if8.result, if8.carry, if8.zero, lat);
    n_vec++; if (if8.result !== 16'h002D) begin n_err++; $display("FAIL add_result: got %h expected 002d", if8.result); end
    n_vec++; if (if8.carry !== 1'b1) begin n_err++; $display("FAIL add_carry: got %b expected 1", if8.carry); end
    n_vec++; if (if8.zero !== 1'b0 || if8.div_by_zero !== 1'b0) begin n_err++; $display("FAIL add_flags: got z=%b dbz=%b expected 0 0", if8.zero, if8.div_by_zero); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
    handoff8();
  endtask

  task automatic test_sub();
    int lat; bit rl;
    issue8(3'b001, 8'd5, 8'd7, 1'b0, lat, rl);
    $display("sub 5-7: result=%h carry=%b zero=%b lat=%0d", if8.result, if8.carry, if8.zero, lat);
    n_vec++; if (if8.result !== 16'h00FE) begin n_err++; $display("FAIL sub_borrow_result: got %h expected 00fe", if8.result); end
    n_vec++; if (if8.carry !== 1'b1) begin n_err++; $display("FAIL sub_borrow_carry: got %b expected 1", if8.carry); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL sub_latency: got %0d expected 1", lat); end
    handoff8();
    // cin must be ignored by sub
    issue8(3'b001, 8'd9, 8'd9, 1'b1, lat, rl);
    $display("sub 9-9: result=%h carry=%b zero=%b lat=%0d", if8.result, if8.carry, if8.zero, lat);
    n_vec++; if (if8.result !== 16'h0000) begin n_err++; $display("FAIL sub_equal_result: got %h expected 0000", if8.result); end
    n_vec++; if (if8.zero !== 1'b1 || if8.carry !== 1'b0) begin n_err++; $display("FAIL sub_equal_flags: got z=%b c=%b expected 1 0", if8.zero, if8.carry); end
    handoff8();
  endtask

  task automatic test_mul();
    int lat; bit rl;
    issue8(3'b010, 8'd255, 8'd255, 1'b0, lat, rl);
    $display("mul 255*255: result=%h carry=%b lat=%0d", if8.result, if8.carry, lat);
    n_vec++; if (if8.result !== 16'hFE01) begin n_err++; $display("FAIL mul_result: got %h expected fe01", if8.result); end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL mul_latency: got %0d expected 9", lat); end
    n_vec++; if (rl !== 1'b1) begin n_err++; $display("FAIL mul_in_ready_busy: got in_ready high during busy, expected low"); end
    n_vec++; if (if8.carry !== 1'b0 || if8.zero !== 1'b0) begin n_err++; $display("FAIL mul_flags: got c=%b z=%b expected 0 0", if8.carry, if8.zero); end
    handoff8();
    issue8(3'b010, 8'd0, 8'd77, 1'b0, lat, rl);
    $display("mul 0*77: result=%h zero=%b lat=%0d", if8.result, if8.zero, lat);
    n_vec++; if (if8.result !== 16'h0000 || if8.zero !== 1'b1) begin n_err++; $display("FAIL mul_zero: got %h z=%b expected 0000 1", if8.result, if8.zero); end
    handoff8();
  endtask

  task automatic test_div();
    int lat; bit rl;
    issue8(3'b011, 8'd200, 8'd7, 1'b0, lat, rl);
    $display("div 200/7: result=%h dbz=%b lat=%0d", if8.result, if8.div_by_zero, lat);
    n_vec++; if (if8.result !== 16'h041C) begin n_err++; $display("FAIL div_result: got %h expected 041c", if8.result); end
    n_vec++; if (if8.div_by_zero !== 1'b0 || if8.carry !== 1'b0) begin n_err++; $display("FAIL div_flags: got dbz=%b c=%b expected 0 0", if8.div_by_zero, if8.carry); end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL div_latency: got %0d expected 9", lat); end
    handoff8();
    issue8(3'b011, 8'd255, 8'd16, 1'b0, lat, rl);
    $display("div 255/16: result=%h lat=%0d", if8.result, lat);
    n_vec++; if (if8.result !== 16'h0F0F) begin n_err++; $display("FAIL div_255_16: got %h expected 0f0f", if8.result); end
    handoff8();
    issue8(3'b011, 8'h55, 8'd0, 1'b0, lat, rl);
    $display("div 0x55/0: result=%h dbz=%b lat=%0d", if8.result, if8.div_by_zero, lat);
    n_vec++; if (if8.result !== 16'h55FF) begin n_err++; $display("FAIL divz_result: got %h expected 55ff", if8.result); end
    n_vec++; if (if8.div_by_zero !== 1'b1) begin n_err++; $display("FAIL divz_flag: got %b expected 1", if8.div_by_zero); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL divz_latency: got %0d expected 1", lat); end
    handoff8();
  endtask

  task automatic test_reserved();
    int lat; bit rl;
    issue8(3'b101, 8'd3, 8'd4, 1'b1, lat, rl);
    $display("reserved op 101: result=%h carry=%b zero=%b lat=%0d", if8.result, if8.carry, if8.zero, lat);
    n_vec++; if (if8.result !== 16'h0000 || if8.carry !== 1'b0 || if8.zero !== 1'b1) begin
      n_err++; $display("FAIL reserved_outputs: got %h c=%b z=%b expected 0000 0 1", if8.result, if8.carry, if8.zero);
    end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL reserved_latency: got %0d expected 1", lat); end
    handoff8();
  endtask

  task automatic test_stall();
    int lat; bit rl; int bad;
    issue8(3'b010, 8'd3, 8'd4, 1'b0, lat, rl);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (if8.out_valid !== 1'b1 || if8.result !== 16'h000C || if8.in_ready !== 1'b0) bad++;
      // a competing command while stalled must be ignored
      if8.in_valid = 1'b1; if8.op = 3'b000; if8.a = 8'h77; if8.b = 8'h01;
      @(posedge clk);
      @(negedge clk);
    end
    if8.in_valid = 1'b0;
    $display("mul 3*4 stalled 5 cycles: result=%h lat=%0d bad_samples=%0d", if8.result, lat, bad);
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL stall_latency: got %0d expected 9", lat); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable samples expected 0", bad); end
    n_vec++; if (if8.result !== 16'h000C || if8.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_result: got %h v=%b expected 000c 1", if8.result, if8.out_valid); end
    handoff8();
    n_vec++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_handoff: got v=%b rdy=%b expected 0 1", if8.out_valid, if8.in_ready); end
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (if8.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_phantom: got out_valid %b expected 0", if8.out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat; bit rl;
    if8.out_ready = 1'b1;
    issue8(3'b000, 8'd1, 8'd2, 1'b0, lat, rl);
    $display("b2b add 1+2: result=%h lat=%0d", if8.result, lat);
    n_vec++; if (if8.result !== 16'h0003 || lat !== 1) begin n_err++; $display("FAIL b2b_add: got %h lat=%0d expected 0003 lat=1", if8.result, lat); end
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_first_done_handoff: got v=%b rdy=%b expected 0 1", if8.out_valid, if8.in_ready); end
    issue8(3'b001, 8'd10, 8'd3, 1'b0, lat, rl);
    $display("b2b sub 10-3: result=%h carry=%b", if8.result, if8.carry);
    n_vec++; if (if8.result !== 16'h0007 || if8.carry !== 1'b0) begin n_err++; $display("FAIL b2b_sub: got %h c=%b expected 0007 0", if8.result, if8.carry); end
    @(posedge clk);
    @(negedge clk);
    issue8(3'b011, 8'd100, 8'd10, 1'b0, lat, rl);
    $display("b2b div 100/10: result=%h lat=%0d", if8.result, lat);
    n_vec++; if (if8.result !== 16'h000A || lat !== 9) begin n_err++; $display("FAIL b2b_div: got %h lat=%0d expected 000a lat=9", if8.result, lat); end
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    int lat; int seen;
    @(negedge clk);
    if16.op = 3'b010; if16.a = 16'hFFFF; if16.b = 16'h0002; if16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("w16 reset in busy: in_ready=%0b out_valid=%0b result=%h", if16.in_ready, if16.out_valid, if16.result);
    n_vec++; if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_hs: got rdy=%b v=%b expected 1 0", if16.in_ready, if16.out_valid); end
    n_vec++; if ({if16.result, if16.carry, if16.zero, if16.div_by_zero} !== 35'h0) begin
      n_err++; $display("FAIL rst_busy_outputs: got %h c=%b z=%b dbz=%b expected all 0", if16.result, if16.carry, if16.zero, if16.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if16.out_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_busy_discard: got %0d out_valid samples expected 0", seen); end
    if16.out_ready = 1'b0;
    issue16(3'b010, 16'hFFFF, 16'h0002, lat);
    $display("w16 mul 0xffff*2: result=%h lat=%0d", if16.result, lat);
    n_vec++; if (if16.result !== 32'h0001FFFE) begin n_err++; $display("FAIL w16_mul_result: got %h expected 0001fffe", if16.result); end
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL w16_mul_latency: got %0d expected 17", lat); end
    if16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.op = '0; if8.out_ready = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.op = '0; if16.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_reserved();
    test_stall();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
